inst_fetcher: RTL and testbench

Instruction fetch stage directly upstream of the instruction cache and the decoder. Owns the program counter, probes the instruction cache combinationally each cycle, and on a hit delivers the instruction through a one-entry output register. On a miss it fetches the 32-bit word from the memory controller, writes it into the cache, and delivers it. It handles 16-bit compressed and 32-bit instructions and branch redirects, including redirects that arrive while a miss is outstanding.

---
 rtl/inst_fetcher.sv | 150 +++++++++++++++
 tb/tb_inst_fetcher.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: owns the PC, probes the icache every cycle, refills from memory on a
// miss and presents one instruction at a time through a registered output slot.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] cache_addr,
  input  logic        cache_hit,
  input  logic [31:0] cache_data,
  output logic        cache_update,
  output logic [31:0] cache_update_addr,
  output logic [31:0] cache_update_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_is_c
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {RUN, MISS_WAIT, MISS_DROP} state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   pc, pc_n;
  logic [XLEN-1:0]   inst_n, inst_pc_n, mem_addr_n, upd_addr_n, upd_data_n;
  logic [XLEN-1:0]   jump_pc, load_word;
  logic              valid_n, is_c_n, mem_req_n, upd_n;
  logic              can_load, load, load_is_c;

  assign cache_addr = pc;
  assign can_load   = !inst_valid || inst_ready;
  assign jump_pc    = jump_addr & ~XLEN'(1);
  assign load_is_c  = (load_word[1:0] != 2'b11);

  // Next-state and next-output selection; a single load path serves both hit and refill delivery.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    valid_n    = inst_valid;
    inst_n     = inst;
    inst_pc_n  = inst_pc;
    is_c_n     = inst_is_c;
    mem_req_n  = mem_req;
    mem_addr_n = mem_addr;
    upd_n      = 1'b0;
    upd_addr_n = cache_update_addr;
    upd_data_n = cache_update_data;
    load       = 1'b0;
    load_word  = '0;

    if (inst_valid && inst_ready) valid_n = 1'b0;

    unique case (state)
      RUN: begin
        if (jump_en) begin
          valid_n = 1'b0;
          pc_n    = jump_pc;
        end else if (cache_hit) begin
          if (can_load) begin
            load      = 1'b1;
            load_word = cache_data;
          end
        end else begin
          mem_req_n  = 1'b1;
          mem_addr_n = pc;
          state_n    = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (mem_done) begin
          mem_req_n  = 1'b0;
          upd_n      = 1'b1;
          upd_addr_n = mem_addr;
          upd_data_n = mem_data;
          state_n    = RUN;
          if (jump_en) begin
            valid_n = 1'b0;
            pc_n    = jump_pc;
          end else if (can_load) begin
            load      = 1'b1;
            load_word = mem_data;
          end
        end else if (jump_en) begin
          // The controller cannot abort, so keep requesting and discard the word later.
          valid_n = 1'b0;
          pc_n    = jump_pc;
          state_n = MISS_DROP;
        end
      end
      MISS_DROP: begin
        if (jump_en) pc_n = jump_pc;
        if (mem_done) begin
          mem_req_n  = 1'b0;
          upd_n      = 1'b1;
          upd_addr_n = mem_addr;
          upd_data_n = mem_data;
          state_n    = RUN;
        end
      end
      default: state_n = RUN;
    endcase

    if (load) begin
      valid_n   = 1'b1;
      inst_n    = load_word;
      inst_pc_n = pc;
      is_c_n    = load_is_c;
      pc_n      = pc + (load_is_c ? XLEN'(2) : XLEN'(4));
    end
  end

  // State and output registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state             <= RUN;
      pc                <= RESET_PC;
      inst_valid        <= 1'b0;
      inst              <= '0;
      inst_pc           <= '0;
      inst_is_c         <= 1'b0;
      mem_req           <= 1'b0;
      mem_addr          <= '0;
      cache_update      <= 1'b0;
      cache_update_addr <= '0;
      cache_update_data <= '0;
    end else if (rdy_in) begin
      state             <= state_n;
      pc                <= pc_n;
      inst_valid        <= valid_n;
      inst              <= inst_n;
      inst_pc           <= inst_pc_n;
      inst_is_c         <= is_c_n;
      mem_req           <= mem_req_n;
      mem_addr          <= mem_addr_n;
      cache_update      <= upd_n;
      cache_update_addr <= upd_addr_n;
      cache_update_data <= upd_data_n;
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a small icache model and a fixed-latency memory responder.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic [31:0] cache_addr;
  logic        cache_hit;
  logic [31:0] cache_data;
  logic        cache_update;
  logic [31:0] cache_update_addr, cache_update_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst, inst_pc;
  logic        inst_is_c;

  int tests = 0;
  int fails = 0;

  inst_fetcher #(.RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cache_addr(cache_addr), .cache_hit(cache_hit), .cache_data(cache_data),
    .cache_update(cache_update), .cache_update_addr(cache_update_addr),
    .cache_update_data(cache_update_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_is_c(inst_is_c)
  );

  always #5 clk_in = ~clk_in;

  // Cache model over 0x00..0xFF: a halfword-indexed image, a miss mask, and refilled lines.
  logic [31:0]  img   [128];
  logic [31:0]  fdat  [128];
  logic [127:0] miss_mask = '0;
  logic [127:0] filled;
  logic [6:0]   cidx;

  always_comb begin
    cidx       = cache_addr[7:1];
    cache_hit  = (cache_addr[31:8] == 24'h0) && (!miss_mask[cidx] || filled[cidx]);
    cache_data = filled[cidx] ? fdat[cidx] : img[cidx];
  end

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) filled <= '0;
    else if (rdy_in && cache_update && cache_update_addr[31:8] == 24'h0) begin
      filled[cache_update_addr[7:1]] <= 1'b1;
      fdat[cache_update_addr[7:1]]   <= cache_update_data;
    end
  end

  // Memory responder: pulses mem_done lat cycles after it first sees mem_req.
  int lat = 3;
  int cnt;
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_done <= 1'b0;
      mem_data <= '0;
      cnt      <= 0;
    end else if (rdy_in) begin
      if (mem_done) begin
        mem_done <= 1'b0;
        cnt      <= 0;
      end else if (mem_req) begin
        if (cnt >= lat - 1) begin
          mem_done <= 1'b1;
          mem_data <= img[mem_addr[7:1]];
        end else cnt <= cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic setup_image(input int miss_idx);
    for (int i = 0; i < 128; i++) img[i] = 32'h0000_0013;
    miss_mask = '0;
    if (miss_idx >= 0) miss_mask[miss_idx] = 1'b1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst inst_valid", 32'(inst_valid), 32'h0);
    chk("rst inst", inst, 32'h0);
    chk("rst inst_pc", inst_pc, 32'h0);
    chk("rst inst_is_c", 32'(inst_is_c), 32'h0);
    chk("rst mem_req", 32'(mem_req), 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst cache_update", 32'(cache_update), 32'h0);
    chk("rst cache_update_addr", cache_update_addr, 32'h0);
    chk("rst cache_update_data", cache_update_data, 32'h0);
    chk("rst cache_addr", cache_addr, 32'h0);
  endtask

  task automatic do_reset();
    rdy_in = 1'b1; jump_en = 1'b0; jump_addr = '0; inst_ready = 1'b1;
    rst_in = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
  endtask

  // sel 0: wait for mem_req high; sel 1: wait for mem_done high. Expiry counts as a failure.
  task automatic wait_for(input int sel, input string name);
    for (int i = 0; i < 20; i++) begin
      step();
      if ((sel == 0 && mem_req) || (sel == 1 && mem_done)) return;
    end
    tests++;
    fails++;
    $display("FAIL %s: timed out after 20 cycles", name);
  endtask

  typedef struct {
    logic        ready;
    logic        jump;
    logic [31:0] jaddr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_caddr;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Streaming, stall, and redirect vectors; inputs apply before the edge, outputs checked after.
    tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 32'h04};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'h08};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 32'h0C};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0C, 32'h10};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 32'h10};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 32'h10};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 32'h10};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 32'h10};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 32'h10};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 32'h14};
    tbl[10] = '{1'b1, 1'b1, 32'h41, 1'b0, 32'h00, 32'h40};
    tbl[11] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 32'h44};
    tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 32'h44};
    tbl[13] = '{1'b0, 1'b1, 32'h81, 1'b0, 32'h00, 32'h80};
    tbl[14] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h80, 32'h84};
    tbl[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h80, 32'h84};

    setup_image(-1);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      inst_ready = tbl[i].ready;
      jump_en    = tbl[i].jump;
      jump_addr  = tbl[i].jaddr;
      step();
      jump_en = 1'b0;
      chk($sformatf("vec%0d inst_valid", i), 32'(inst_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("vec%0d cache_addr", i), cache_addr, tbl[i].exp_caddr);
      if (tbl[i].exp_valid) begin
        chk($sformatf("vec%0d inst_pc", i), inst_pc, tbl[i].exp_pc);
        chk($sformatf("vec%0d inst", i), inst, 32'h0000_0013);
        chk($sformatf("vec%0d inst_is_c", i), 32'(inst_is_c), 32'h0);
      end
    end

    // Mixed 16/32-bit stream.
    setup_image(-1);
    img[0] = 32'h0000_4501;
    img[1] = 32'h0000_0505;
    img[2] = 32'h00A0_0093;
    do_reset();
    begin
      logic [31:0] epc [4];
      logic        ec  [4];
      epc = '{32'h0, 32'h2, 32'h4, 32'h8};
      ec  = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
        step();
        chk($sformatf("rvc%0d inst_valid", i), 32'(inst_valid), 32'h1);
        chk($sformatf("rvc%0d inst_pc", i), inst_pc, epc[i]);
        chk($sformatf("rvc%0d inst_is_c", i), 32'(inst_is_c), 32'(ec[i]));
      end
    end

    // Miss at 0x10 with a 3-cycle memory.
    setup_image(8);
    img[8] = 32'h00A0_0093;
    lat = 3;
    do_reset();
    repeat (4) step();
    chk("miss pre mem_req", 32'(mem_req), 32'h0);
    step();
    chk("miss mem_req rise", 32'(mem_req), 32'h1);
    chk("miss mem_addr", mem_addr, 32'h10);
    wait_for(1, "miss mem_done");
    chk("miss mem_addr held", mem_addr, 32'h10);
    step();
    chk("miss cache_update", 32'(cache_update), 32'h1);
    chk("miss cache_update_addr", cache_update_addr, 32'h10);
    chk("miss cache_update_data", cache_update_data, 32'h00A0_0093);
    chk("miss mem_req drop", 32'(mem_req), 32'h0);
    chk("miss inst_valid", 32'(inst_valid), 32'h1);
    chk("miss inst", inst, 32'h00A0_0093);
    chk("miss inst_pc", inst_pc, 32'h10);
    step();
    chk("miss update one cycle", 32'(cache_update), 32'h0);
    chk("miss next inst_pc", inst_pc, 32'h14);

    // Redirect while the 0x20 refill is outstanding.
    setup_image(16);
    img[16] = 32'hDEAD_0013;
    lat = 4;
    do_reset();
    wait_for(0, "drop mem_req");
    chk("drop mem_addr", mem_addr, 32'h20);
    jump_en = 1'b1;
    jump_addr = 32'h41;
    step();
    jump_en = 1'b0;
    chk("drop inst_valid after jump", 32'(inst_valid), 32'h0);
    chk("drop mem_req held", 32'(mem_req), 32'h1);
    chk("drop cache_addr", cache_addr, 32'h40);
    wait_for(1, "drop mem_done");
    chk("drop no delivery while waiting", 32'(inst_valid), 32'h0);
    chk("drop mem_req still held", 32'(mem_req), 32'h1);
    step();
    chk("drop cache_update", 32'(cache_update), 32'h1);
    chk("drop cache_update_addr", cache_update_addr, 32'h20);
    chk("drop cache_update_data", cache_update_data, 32'hDEAD_0013);
    chk("drop mem_req released", 32'(mem_req), 32'h0);
    chk("drop 0x20 not delivered", 32'(inst_valid), 32'h0);
    step();
    chk("drop target inst_valid", 32'(inst_valid), 32'h1);
    chk("drop target inst_pc", inst_pc, 32'h40);

    // rdy_in freeze mid-stream, then reset during an outstanding miss.
    setup_image(8);
    lat = 6;
    do_reset();
    step();
    step();
    chk("pause pre inst_pc", inst_pc, 32'h4);
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("pause%0d inst_pc", i), inst_pc, 32'h4);
      chk($sformatf("pause%0d cache_addr", i), cache_addr, 32'h8);
    end
    rdy_in = 1'b1;
    step();
    chk("resume inst_pc", inst_pc, 32'h8);
    step();
    step();
    chk("rstmiss mem_req", 32'(mem_req), 32'h1);
    step();
    do_reset();
    step();
    chk("restart inst_valid", 32'(inst_valid), 32'h1);
    chk("restart inst_pc", inst_pc, 32'h0);
    chk("restart mem_req", 32'(mem_req), 32'h0);

    // Redirect to an odd address at the top of memory; PC then wraps to 0.
    setup_image(-1);
    img[127] = 32'h0000_0001;
    lat = 2;
    do_reset();
    jump_en = 1'b1;
    jump_addr = 32'hFFFF_FFFF;
    step();
    jump_en = 1'b0;
    chk("wrap cache_addr", cache_addr, 32'hFFFF_FFFE);
    wait_for(0, "wrap mem_req");
    chk("wrap mem_addr", mem_addr, 32'hFFFF_FFFE);
    wait_for(1, "wrap mem_done");
    step();
    chk("wrap inst_pc", inst_pc, 32'hFFFF_FFFE);
    chk("wrap inst_is_c", 32'(inst_is_c), 32'h1);
    step();
    chk("wrap next inst_pc", inst_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
